// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
//
// Load/store unit for the MEM stage. It takes the EX/MEM register outputs,
// runs one valid/ready transaction to the data memory per access, and holds
// the pipeline with lsu_stall until the transaction has finished. Load data
// is extended and registered into ReadData_M for the MEM/WB register.
//
// Each access takes IDLE -> REQ (one cycle per memory wait, plus one) -> DONE.
// lsu_stall is high in IDLE while an access is present and throughout REQ. It
// is low in DONE, which lets the pipeline advance at the end of that cycle.
//
// Optional feature (compile-time macro MISALIGN_TRAP_EN):
//   undefined : misaligned half/word accesses are silently aligned.
//   defined   : a misaligned half/word access issues no request. The FSM goes
//               IDLE -> DONE, misalign_M pulses for the DONE cycle, and
//               ReadData_M is cleared.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   MemWrite_M          store in the MEM stage
//   ResultSrc_M         equals LOAD_SEL for a load (a store wins if both are set)
//   funct3_M            size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
//   ALU_result_M        byte address
//   WriteData_M         store data in the low-order bytes
//   mem_req/we/addr     registered request, word-aligned address
//   mem_wdata/wstrb     registered lane-replicated store data and byte enables
//   mem_ready           memory accepts/completes the request this cycle
//   mem_rdata           read word, valid with mem_req & mem_ready
//   ReadData_M          registered extended load result
//   lsu_stall           pipeline freeze, decoded from the state
//   misalign_M          misalignment flag (only with MISALIGN_TRAP_EN)
// -----------------------------------------------------------------------------
module mem_stage_lsu #(
    parameter int                         ADDR_WIDTH      = 32,
    parameter int                         DATA_WIDTH      = 32,
    parameter int                         RESULTSRC_WIDTH = 2,
    parameter logic [RESULTSRC_WIDTH-1:0] LOAD_SEL        = 2'b01
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       MemWrite_M,
    input  logic [RESULTSRC_WIDTH-1:0] ResultSrc_M,
    input  logic [2:0]                 funct3_M,
    input  logic [ADDR_WIDTH-1:0]      ALU_result_M,
    input  logic [DATA_WIDTH-1:0]      WriteData_M,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_wdata,
    output logic [DATA_WIDTH/8-1:0]    mem_wstrb,
    input  logic                       mem_ready,
    input  logic [DATA_WIDTH-1:0]      mem_rdata,
    output logic [DATA_WIDTH-1:0]      ReadData_M,
    output logic                       lsu_stall
`ifdef MISALIGN_TRAP_EN
    ,
    output logic                       misalign_M
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       access;
    logic       stall_c;
    logic [2:0] f3_q;
    logic [1:0] off_q;

    // Byte enables for a store. funct3[1:0] selects the size; 011 is a word.
    function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] s;
        case (size)
            2'b00:   s = 4'b0001 << off;
            2'b01:   s = off[1] ? 4'b1100 : 4'b0011;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    // Store data replicated across every lane the access could land in.
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] d;
        case (size)
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    // Picks the addressed byte/half from the read word and extends it.
    // funct3[2] set means zero-extension; 110/111 are words and pass through.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] word);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        res;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3[1:0])
            2'b00:   res = f3[2] ? {24'd0, b} : 32'(b);
            2'b01:   res = f3[2] ? {16'd0, h} : 32'(h);
            default: res = word;
        endcase
        return res;
    endfunction

`ifdef MISALIGN_TRAP_EN
    logic misalign_c;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic m;
        case (size)
            2'b00:   m = 1'b0;
            2'b01:   m = off[0];
            default: m = (off != 2'b00);
        endcase
        return m;
    endfunction

    assign misalign_c = is_misaligned(funct3_M[1:0], ALU_result_M[1:0]);
`endif

    assign access = MemWrite_M | (ResultSrc_M == LOAD_SEL);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and stall decode
    always_comb begin
        state_d = state_q;
        stall_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    stall_c = 1'b1;
`ifdef MISALIGN_TRAP_EN
                    state_d = misalign_c ? DONE : REQ;
`else
                    state_d = REQ;
`endif
                end
            end
            REQ: begin
                stall_c = 1'b1;
                if (mem_ready) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The stall must also read 0 while reset is held, even if an access is
    // sitting on the inputs.
    assign lsu_stall = stall_c & rst_n;

    // Request and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            ReadData_M <= '0;
            f3_q       <= '0;
            off_q      <= '0;
`ifdef MISALIGN_TRAP_EN
            misalign_M <= 1'b0;
`endif
        end else begin
`ifdef MISALIGN_TRAP_EN
            misalign_M <= (state_q == IDLE) && access && misalign_c;
`endif
            case (state_q)
                IDLE: begin
                    if (access) begin
                        mem_we    <= MemWrite_M;
                        mem_addr  <= {ALU_result_M[ADDR_WIDTH-1:2], 2'b00};
                        mem_wdata <= store_data(funct3_M[1:0], WriteData_M);
                        mem_wstrb <= MemWrite_M ? store_strb(funct3_M[1:0], ALU_result_M[1:0])
                                                : 4'b0000;
                        f3_q      <= funct3_M;
                        off_q     <= ALU_result_M[1:0];
`ifdef MISALIGN_TRAP_EN
                        if (misalign_c) begin
                            ReadData_M <= '0;
                        end else begin
                            mem_req <= 1'b1;
                        end
`else
                        mem_req <= 1'b1;
`endif
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            ReadData_M <= load_extend(f3_q, off_q, mem_rdata);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
